// File: rtl/hack_pkg.sv
// Shared Hack platform constants, address-map decode and screen FIFO entry type.
// Imported by the data-memory responder and its FIFO user.
package hack_pkg;

    localparam int WORD_W    = 16;
    localparam int ADDR_W    = 15;
    localparam int SCR_OFF_W = 13;
    localparam int RAM_WORDS = 16384;
    localparam int SCR_WORDS = 8192;

    localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;
    localparam logic [ADDR_W-1:0] KBD_ADDR    = 15'h6000;
    localparam logic [ADDR_W-1:0] RAM_TOP     = 15'h3FFF;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_SCR,
        REG_KBD,
        REG_NONE
    } region_e;

    typedef struct packed {
        logic [SCR_OFF_W-1:0] addr;
        logic [WORD_W-1:0]    data;
    } scr_entry_t;

    // RAM is everything below the screen base; the screen runs up to
    // the keyboard register; anything above the keyboard is unmapped.
    function automatic region_e decode(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] sb,
        input logic [ADDR_W-1:0] kb
    );
        region_e r;
        if (a < sb)
            r = REG_RAM;
        else if (a < kb)
            r = REG_SCR;
        else if (a == kb)
            r = REG_KBD;
        else
            r = REG_NONE;
        return r;
    endfunction

endpackage

// File: rtl/hack_sync_fifo.sv
// Synchronous FIFO with push/pop/full/empty/count; power-of-two depth.
// Ports: clk, reset (sync, active-low), push/din, pop/dout, full, empty, count.
module hack_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic             do_pop;
    logic             do_push;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rp];

    // A pop frees the slot the push needs, so push-while-full is
    // accepted only when a pop happens on the same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push)
                wp <= wp + 1'b1;
            if (do_pop)
                rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && do_push)
            mem[wp] <= din;
    end

endmodule

// File: rtl/hack_data_mem.sv
// Hack data-memory responder: RAM, screen, keyboard; screen writes forwarded via FIFO.
// Ports: clk, reset, addressM/outM/writeM -> inM, kbd_valid/kbd_code, scr_* stream, scr_overflow.
module hack_data_mem #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [14:0] KBD_ADDR    = hack_pkg::KBD_ADDR,
    parameter logic [14:0] SCREEN_BASE = hack_pkg::SCREEN_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    input  logic        kbd_valid,
    input  logic [15:0] kbd_code,
    output logic        scr_valid,
    output logic [12:0] scr_addr,
    output logic [15:0] scr_data,
    input  logic        scr_ready,
    output logic        scr_overflow
);

    import hack_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [WORD_W-1:0]    ram [RAM_WORDS];
    logic [WORD_W-1:0]    scr [SCR_WORDS];
    logic [WORD_W-1:0]    kbd;
    logic                 ovf;

    region_e              rgn;
    logic [SCR_OFF_W-1:0] scr_off;
    logic                 wr_ram;
    logic                 wr_scr;
    logic                 drop;

    scr_entry_t           fifo_in;
    scr_entry_t           fifo_out;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;

    assign rgn     = decode(addressM, SCREEN_BASE, KBD_ADDR);
    assign scr_off = SCR_OFF_W'(addressM - SCREEN_BASE);

    // CPU writes are suppressed while reset is asserted.
    assign wr_ram  = reset & writeM & (rgn == REG_RAM);
    assign wr_scr  = reset & writeM & (rgn == REG_SCR);

    // Full with no effective pop on the same edge loses the entry.
    assign drop    = wr_scr & fifo_full & ~(scr_ready & ~fifo_empty);

    assign fifo_in = '{addr: scr_off, data: outM};

    always_ff @(posedge clk) begin
        if (wr_ram)
            ram[addressM[13:0]] <= outM;
        if (wr_scr)
            scr[scr_off] <= outM;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            kbd <= '0;
            ovf <= 1'b0;
        end else begin
            if (kbd_valid)
                kbd <= kbd_code;
            if (drop)
                ovf <= 1'b1;
        end
    end

    always_comb begin
        inM = '0;
        unique case (rgn)
            REG_RAM:  inM = ram[addressM[13:0]];
            REG_SCR:  inM = scr[scr_off];
            REG_KBD:  inM = kbd;
            REG_NONE: inM = '0;
        endcase
    end

    hack_sync_fifo #(
        .WIDTH ($bits(scr_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_scr),
        .din   (fifo_in),
        .pop   (scr_ready),
        .dout  (fifo_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign scr_valid    = (fifo_count != '0);
    assign scr_addr     = fifo_out.addr;
    assign scr_data     = fifo_out.data;
    assign scr_overflow = ovf;

endmodule

// File: tb/tb_hack_data_mem.sv
// Scoreboard bench for hack_data_mem: directed stimulus queues expectations,
// a negedge monitor pops and compares them and every screen-stream handshake.
module tb_hack_data_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic        kbd_valid;
    logic [15:0] kbd_code;
    logic        scr_valid;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        scr_ready;
    logic        scr_overflow;

    always #5 clk = ~clk;

    hack_data_mem #(
        .FIFO_DEPTH  (4),
        .KBD_ADDR    (15'h6000),
        .SCREEN_BASE (15'h4000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .addressM     (addressM),
        .outM         (outM),
        .writeM       (writeM),
        .inM          (inM),
        .kbd_valid    (kbd_valid),
        .kbd_code     (kbd_code),
        .scr_valid    (scr_valid),
        .scr_addr     (scr_addr),
        .scr_data     (scr_data),
        .scr_ready    (scr_ready),
        .scr_overflow (scr_overflow)
    );

    localparam int K_INM   = 0;
    localparam int K_VALID = 1;
    localparam int K_ADDR  = 2;
    localparam int K_DATA  = 3;
    localparam int K_OVF   = 4;
    localparam int K_SQ    = 5;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] exp;
    } chk_t;

    chk_t        chk_q[$];
    logic [28:0] scr_q[$];
    int          passed = 0;
    int          total  = 0;

    function automatic logic [15:0] observe(input int kind);
        logic [15:0] v;
        case (kind)
            K_INM:   v = inM;
            K_VALID: v = {15'b0, scr_valid};
            K_ADDR:  v = {3'b0, scr_addr};
            K_DATA:  v = scr_data;
            K_OVF:   v = {15'b0, scr_overflow};
            default: v = 16'(scr_q.size());
        endcase
        return v;
    endfunction

    task automatic expect_now(input string n, input int k, input logic [15:0] e);
        chk_t c;
        c.name = n;
        c.kind = k;
        c.exp  = e;
        chk_q.push_back(c);
    endtask

    always @(negedge clk) begin
        chk_t        c;
        logic [15:0] act;
        logic [28:0] e;
        while (chk_q.size() > 0) begin
            c   = chk_q.pop_front();
            act = observe(c.kind);
            total++;
            if (act === c.exp)
                passed++;
            else
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
        if (scr_valid === 1'b1 && scr_ready === 1'b1) begin
            total++;
            if (scr_q.size() == 0) begin
                $display("FAIL scr_pop: got %h/%h expected no entry",
                         scr_addr, scr_data);
            end else begin
                e = scr_q.pop_front();
                if ({scr_addr, scr_data} === e)
                    passed++;
                else
                    $display("FAIL scr_pop: got %h/%h expected %h/%h",
                             scr_addr, scr_data, e[28:16], e[15:0]);
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        addressM = a;
        outM     = d;
        writeM   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b0;
        addressM  = '0;
        outM      = '0;
        writeM    = 1'b0;
        kbd_valid = 1'b0;
        kbd_code  = '0;
        scr_ready = 1'b0;
        cyc;
        cyc;
        reset    = 1'b1;
        addressM = 15'h6000;
        expect_now("rst_kbd", K_INM, 16'd0);
        expect_now("rst_valid", K_VALID, 16'd0);
        expect_now("rst_ovf", K_OVF, 16'd0);

        // RAM write / read-after-write
        cyc; wr(15'd1004, 16'd222);
        cyc; wr(15'd1003, 16'd11111);
        cyc;
        writeM   = 1'b0;
        addressM = 15'd1003;
        expect_now("ram_1003", K_INM, 16'd11111);
        cyc;
        addressM = 15'd1004;
        expect_now("ram_1004", K_INM, 16'd222);

        // Screen forward
        cyc; wr(15'h4005, 16'hFFFF);
        scr_q.push_back({13'd5, 16'hFFFF});
        cyc;
        writeM = 1'b0;
        expect_now("scr_rd", K_INM, 16'hFFFF);
        expect_now("scr_valid1", K_VALID, 16'd1);
        expect_now("scr_addr5", K_ADDR, 16'd5);
        expect_now("scr_dataF", K_DATA, 16'hFFFF);
        cyc;
        scr_ready = 1'b1;
        cyc;
        scr_ready = 1'b0;
        expect_now("scr_drained", K_VALID, 16'd0);

        // Fill and overflow
        for (int i = 0; i < 5; i++) begin
            cyc;
            wr(15'h4000 + 15'(i), 16'(i + 1));
            if (i < 4)
                scr_q.push_back({13'(i), 16'(i + 1)});
        end
        cyc;
        writeM   = 1'b0;
        addressM = 15'h4004;
        expect_now("scr4_rd", K_INM, 16'd5);
        expect_now("ovf_set", K_OVF, 16'd1);
        expect_now("full_valid", K_VALID, 16'd1);
        expect_now("full_head", K_DATA, 16'd1);

        // Push and pop together while full
        cyc;
        wr(15'h4006, 16'd9);
        scr_ready = 1'b1;
        scr_q.push_back({13'd6, 16'd9});
        cyc;
        writeM    = 1'b0;
        scr_ready = 1'b0;
        expect_now("pp_ovf", K_OVF, 16'd1);
        expect_now("pp_head", K_DATA, 16'd2);
        expect_now("scr6_rd", K_INM, 16'd9);
        for (int i = 0; i < 4; i++) begin
            cyc;
            scr_ready = 1'b1;
        end
        cyc;
        scr_ready = 1'b0;
        expect_now("drain_empty", K_VALID, 16'd0);
        expect_now("drain_sq", K_SQ, 16'd0);

        // Keyboard
        cyc;
        kbd_valid = 1'b1;
        kbd_code  = 16'd75;
        cyc;
        kbd_valid = 1'b0;
        kbd_code  = 16'd0;
        addressM  = 15'h6000;
        expect_now("kbd_75", K_INM, 16'd75);
        cyc; wr(15'h6000, 16'd0);
        cyc;
        writeM = 1'b0;
        expect_now("kbd_hold", K_INM, 16'd75);
        expect_now("kbd_nopush", K_VALID, 16'd0);
        cyc;
        addressM = 15'h6001;
        expect_now("above_kbd", K_INM, 16'd0);
        cyc;
        addressM = 15'h7FFF;
        expect_now("top_addr", K_INM, 16'd0);

        // Screen top word, push into empty FIFO with ready held high
        cyc;
        wr(15'h5FFF, 16'h1234);
        scr_ready = 1'b1;
        scr_q.push_back({13'h1FFF, 16'h1234});
        cyc;
        writeM = 1'b0;
        expect_now("scr_top_rd", K_INM, 16'h1234);
        expect_now("scr_top_v", K_VALID, 16'd1);
        expect_now("scr_top_a", K_ADDR, 16'h1FFF);
        cyc;
        scr_ready = 1'b0;
        expect_now("scr_top_pop", K_VALID, 16'd0);

        // RAM top word does not reach the FIFO
        cyc; wr(15'h3FFF, 16'hBEEF);
        cyc;
        writeM = 1'b0;
        expect_now("ram_top_rd", K_INM, 16'hBEEF);
        expect_now("ram_top_v", K_VALID, 16'd0);

        // Reset mid-operation: 3 queued entries, KBD=75, overflow set
        for (int i = 0; i < 3; i++) begin
            cyc;
            wr(15'h4010 + 15'(i), 16'h00A0 + 16'(i));
        end
        cyc;
        writeM = 1'b0;
        expect_now("pre_rst_v", K_VALID, 16'd1);
        expect_now("pre_rst_ovf", K_OVF, 16'd1);
        cyc;
        reset     = 1'b0;
        wr(15'd1003, 16'd0);
        kbd_valid = 1'b1;
        kbd_code  = 16'd99;
        cyc;
        reset     = 1'b1;
        writeM    = 1'b0;
        kbd_valid = 1'b0;
        addressM  = 15'h6000;
        expect_now("mid_rst_kbd", K_INM, 16'd0);
        expect_now("mid_rst_v", K_VALID, 16'd0);
        expect_now("mid_rst_ovf", K_OVF, 16'd0);
        cyc;
        addressM = 15'd1003;
        expect_now("ram_kept", K_INM, 16'd11111);
        cyc;
        addressM = 15'h4010;
        expect_now("scr_kept", K_INM, 16'h00A0);
        expect_now("final_sq", K_SQ, 16'd0);
        cyc;
        cyc;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
